// File: rtl/vend_pkg.sv
// Shared types and constants for the change-payout path of the vending machine.
package vend_pkg;

    // Change sequencer FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SELECT    = 3'd1,
        EJECT     = 3'd2,
        WAIT_DROP = 3'd3,
        DONE      = 3'd4,
        FAULT     = 3'd5
    } chg_state_t;

    // Which hopper the current eject targets.
    typedef enum logic {
        NICKEL = 1'b0,
        DIME   = 1'b1
    } coin_sel_t;

    // Value of each coin in nickel units.
    localparam int unsigned NICKEL_UNITS = 1;
    localparam int unsigned DIME_UNITS   = 2;

    // Coin encodings shared with the vending FSM.
    localparam logic [1:0] COIN_5C  = 2'b01;
    localparam logic [1:0] COIN_10C = 2'b10;
    localparam logic [1:0] COIN_25C = 2'b11;

    // Nickel units paid out by one coin of the given kind.
    function automatic logic [1:0] coin_units(input coin_sel_t coin);
        logic [1:0] units;
        case (coin)
            DIME:    units = 2'(DIME_UNITS);
            NICKEL:  units = 2'(NICKEL_UNITS);
            default: units = 2'(NICKEL_UNITS);
        endcase
        return units;
    endfunction

endpackage

// File: rtl/vend_drop_timer.sv
// Drop-sense watchdog: counts cycles spent waiting for a coin to fall and
// flags when the last allowed cycle has been reached.
module vend_drop_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_count;

    // Cycle counter: cleared on each new eject, holds once the limit is reached.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + TW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/vend_change_sequencer.sv
// Change payout controller: pays a nickel-unit amount from a dime hopper and a
// nickel hopper (dimes first), one coin per eject pulse, confirming each coin
// with the drop sensor. Tracks inventory and latches a jam fault.
module vend_change_sequencer
    import vend_pkg::*;
#(
    parameter int AMT_W      = 3,
    parameter int CNT_W      = 6,
    parameter int TIMEOUT    = 16,
    parameter int MAX_CHANGE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amt,
    output logic             req_ready,
    output logic             done,
    output logic [AMT_W-1:0] short_amt,
    output logic             eject_n,
    output logic             eject_d,
    input  logic             drop_sense,
    input  logic             refill_n,
    input  logic             refill_d,
    input  logic [CNT_W-1:0] refill_cnt,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] nickel_cnt,
    output logic [CNT_W-1:0] dime_cnt,
    output logic             exact_only,
    output logic             fault
);

    // Clamp a one-bit-wider sum back into the counter range.
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W:0] value);
        logic [CNT_W-1:0] result;
        if (value[CNT_W]) begin
            result = '1;
        end else begin
            result = value[CNT_W-1:0];
        end
        return result;
    endfunction

    // Registered state
    chg_state_t       r_state;
    logic [AMT_W-1:0] r_remaining;
    coin_sel_t        r_coin;
    logic [AMT_W-1:0] r_short;
    logic [CNT_W-1:0] r_nickel_cnt;
    logic [CNT_W-1:0] r_dime_cnt;

    // Registered outputs
    logic             r_req_ready;
    logic             r_done;
    logic [AMT_W-1:0] r_short_amt;
    logic             r_eject_n;
    logic             r_eject_d;
    logic             r_fault;

    // Next-state terms
    chg_state_t       w_state_nxt;
    logic [AMT_W-1:0] w_remaining_nxt;
    coin_sel_t        w_coin_nxt;
    logic [AMT_W-1:0] w_short_nxt;
    logic             w_dec_n;
    logic             w_dec_d;
    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic             w_tmr_expired;

    // Inventory arithmetic
    logic [CNT_W:0]   w_nickel_sum;
    logic [CNT_W:0]   w_dime_sum;
    logic [CNT_W+1:0] w_guaranteed;

    vend_drop_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_drop_timer (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    // Next-state and datapath decisions for the payout FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_coin_nxt      = r_coin;
        w_short_nxt     = r_short;
        w_dec_n         = 1'b0;
        w_dec_d         = 1'b0;
        w_tmr_clr       = 1'b0;
        w_tmr_en        = 1'b0;
        case (r_state)
            IDLE: begin
                // req_ready is high throughout IDLE, so req_valid alone is the handshake.
                if (req_valid) begin
                    w_remaining_nxt = req_amt;
                    if (req_amt == '0) begin
                        w_short_nxt = '0;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SELECT;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SELECT: begin
                if ((r_remaining >= AMT_W'(2)) && (r_dime_cnt != '0)) begin
                    w_coin_nxt  = DIME;
                    w_state_nxt = EJECT;
                end else if ((r_remaining >= AMT_W'(1)) && (r_nickel_cnt != '0)) begin
                    w_coin_nxt  = NICKEL;
                    w_state_nxt = EJECT;
                end else if (r_remaining == '0) begin
                    w_short_nxt = '0;
                    w_state_nxt = DONE;
                end else begin
                    // Hoppers cannot cover what is left; report it as short.
                    w_short_nxt = r_remaining;
                    w_state_nxt = DONE;
                end
            end
            EJECT: begin
                w_tmr_clr   = 1'b1;
                w_state_nxt = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (drop_sense) begin
                    w_dec_n         = (r_coin == NICKEL);
                    w_dec_d         = (r_coin == DIME);
                    w_remaining_nxt = r_remaining - AMT_W'(coin_units(r_coin));
                    w_state_nxt     = SELECT;
                end else if (w_tmr_expired) begin
                    w_state_nxt = FAULT;
                end else begin
                    w_tmr_en    = 1'b1;
                    w_state_nxt = WAIT_DROP;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            FAULT: begin
                if (fault_clr) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = FAULT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register with outputs decoded from the next state so they
    // change on the same edge as the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_coin      <= NICKEL;
            r_short     <= '0;
            r_req_ready <= 1'b1;
            r_done      <= 1'b0;
            r_short_amt <= '0;
            r_eject_n   <= 1'b0;
            r_eject_d   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_coin      <= w_coin_nxt;
            r_short     <= w_short_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
            r_done      <= (w_state_nxt == DONE);
            r_short_amt <= (w_state_nxt == DONE) ? w_short_nxt : '0;
            r_eject_n   <= (w_state_nxt == EJECT) && (w_coin_nxt == NICKEL);
            r_eject_d   <= (w_state_nxt == EJECT) && (w_coin_nxt == DIME);
            r_fault     <= (w_state_nxt == FAULT);
        end
    end

    // Refill plus optional single-coin decrement; SELECT only picks a
    // non-empty hopper, so the sum is at least 1 whenever a decrement applies.
    always_comb begin
        w_nickel_sum = {1'b0, r_nickel_cnt} + (refill_n ? {1'b0, refill_cnt} : (CNT_W+1)'(0));
        w_dime_sum   = {1'b0, r_dime_cnt} + (refill_d ? {1'b0, refill_cnt} : (CNT_W+1)'(0));
        if (w_dec_n) begin
            w_nickel_sum = w_nickel_sum - (CNT_W+1)'(1);
        end else begin
            w_nickel_sum = w_nickel_sum;
        end
        if (w_dec_d) begin
            w_dime_sum = w_dime_sum - (CNT_W+1)'(1);
        end else begin
            w_dime_sum = w_dime_sum;
        end
    end

    // Hopper inventory registers, saturating at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nickel_cnt <= '0;
            r_dime_cnt   <= '0;
        end else begin
            r_nickel_cnt <= sat_cnt(w_nickel_sum);
            r_dime_cnt   <= sat_cnt(w_dime_sum);
        end
    end

    // Guaranteed change in nickel units, wide enough for two full hoppers.
    assign w_guaranteed = (CNT_W+2)'(r_nickel_cnt) + ((CNT_W+2)'(r_dime_cnt) << 1);

    assign exact_only = (r_nickel_cnt == '0) || (w_guaranteed < (CNT_W+2)'(MAX_CHANGE));

    assign req_ready  = r_req_ready;
    assign done       = r_done;
    assign short_amt  = r_short_amt;
    assign eject_n    = r_eject_n;
    assign eject_d    = r_eject_d;
    assign fault      = r_fault;
    assign nickel_cnt = r_nickel_cnt;
    assign dime_cnt   = r_dime_cnt;

endmodule

// File: tb/tb_vend_change_sequencer.sv
// Self-checking bench for vend_change_sequencer: a greedy payout model pushes
// expected coins and shortfalls into queues that are popped as the DUT ejects
// coins and signals completion. A hopper stub answers each eject with a drop.
module tb_vend_change_sequencer;

    localparam int AMT_W      = 3;
    localparam int CNT_W      = 6;
    localparam int TIMEOUT    = 16;
    localparam int MAX_CHANGE = 4;
    localparam int CNT_MAX    = 63;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic [AMT_W-1:0] req_amt;
    logic             req_ready;
    logic             done;
    logic [AMT_W-1:0] short_amt;
    logic             eject_n;
    logic             eject_d;
    logic             drop_sense;
    logic             refill_n;
    logic             refill_d;
    logic [CNT_W-1:0] refill_cnt;
    logic             fault_clr;
    logic [CNT_W-1:0] nickel_cnt;
    logic [CNT_W-1:0] dime_cnt;
    logic             exact_only;
    logic             fault;

    int n_checks = 0;
    int n_fail   = 0;
    int m_n      = 0;
    int m_d      = 0;
    int q_coin[$];
    int q_short[$];

    always #5 clk = ~clk;

    vend_change_sequencer #(
        .AMT_W      (AMT_W),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .MAX_CHANGE (MAX_CHANGE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_amt    (req_amt),
        .req_ready  (req_ready),
        .done       (done),
        .short_amt  (short_amt),
        .eject_n    (eject_n),
        .eject_d    (eject_d),
        .drop_sense (drop_sense),
        .refill_n   (refill_n),
        .refill_d   (refill_d),
        .refill_cnt (refill_cnt),
        .fault_clr  (fault_clr),
        .nickel_cnt (nickel_cnt),
        .dime_cnt   (dime_cnt),
        .exact_only (exact_only),
        .fault      (fault)
    );

    function automatic logic model_exact();
        return (m_n == 0) || ((m_n + 2 * m_d) < MAX_CHANGE);
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; req_amt = '0; drop_sense = 1'b0;
        refill_n = 1'b0; refill_d = 1'b0; refill_cnt = '0; fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_n = 0; m_d = 0;
        q_coin.delete(); q_short.delete();
    endtask

    task automatic do_refill(input bit is_dime, input int amt);
        @(negedge clk);
        refill_n = !is_dime; refill_d = is_dime; refill_cnt = CNT_W'(amt);
        @(negedge clk);
        refill_n = 1'b0; refill_d = 1'b0; refill_cnt = '0;
        if (is_dime) m_d = (m_d + amt > CNT_MAX) ? CNT_MAX : m_d + amt;
        else         m_n = (m_n + amt > CNT_MAX) ? CNT_MAX : m_n + amt;
    endtask

    // Issue one request; rf_n > 0 refills nickels in the same cycle as the first nickel's drop.
    task automatic pay_and_check(input int amt, input int rf_n, output int lat);
        int rem, cyc, exp_c, exp_s;
        bit first_n, got_done, sense_next, rf_next;
        rem = amt; first_n = 1'b1;
        forever begin
            if (rem >= 2 && m_d > 0) begin
                q_coin.push_back(1); m_d--; rem -= 2;
            end else if (rem >= 1 && m_n > 0) begin
                q_coin.push_back(0);
                if (first_n && rf_n > 0) m_n = (m_n + rf_n - 1 > CNT_MAX) ? CNT_MAX : m_n + rf_n - 1;
                else m_n--;
                first_n = 1'b0; rem -= 1;
            end else break;
        end
        q_short.push_back(rem);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL req_ready_before_req: got %b expected 1", req_ready); end
        req_valid = 1'b1; req_amt = AMT_W'(amt);
        cyc = 0; got_done = 1'b0; sense_next = 1'b0; rf_next = 1'b0; first_n = 1'b1; lat = -1;
        while (!got_done && cyc < 200) begin
            @(negedge clk); cyc++;
            req_valid  = 1'b0;
            drop_sense = sense_next;
            refill_n   = rf_next;
            refill_cnt = rf_next ? CNT_W'(rf_n) : '0;
            sense_next = 1'b0; rf_next = 1'b0;
            if (eject_n || eject_d) begin
                n_checks++;
                if (q_coin.size() == 0) begin
                    n_fail++; $display("FAIL unexpected_eject: got n=%b d=%b expected none", eject_n, eject_d);
                end else begin
                    exp_c = q_coin.pop_front();
                    if ({eject_d, eject_n} !== (exp_c == 1 ? 2'b10 : 2'b01)) begin
                        n_fail++; $display("FAIL eject_coin: got d=%b n=%b expected %s", eject_d, eject_n, exp_c == 1 ? "dime" : "nickel");
                    end
                end
                sense_next = 1'b1;
                if (eject_n && first_n && rf_n > 0) rf_next = 1'b1;
                if (eject_n) first_n = 1'b0;
            end
            n_checks++;
            if (done === 1'b1) begin
                got_done = 1'b1; lat = cyc;
                exp_s = q_short.pop_front();
                if (short_amt !== exp_s[AMT_W-1:0]) begin
                    n_fail++; $display("FAIL short_amt: got %0d expected %0d", short_amt, exp_s);
                end
            end else if (short_amt !== '0) begin
                n_fail++; $display("FAIL short_amt_idle: got %0d expected 0", short_amt);
            end
        end
        drop_sense = 1'b0; refill_n = 1'b0; refill_cnt = '0;
        n_checks++;
        if (!got_done) begin n_fail++; $display("FAIL done_timeout: got no done expected done within 200 cycles"); end
        n_checks++;
        if (q_coin.size() != 0) begin n_fail++; $display("FAIL missing_ejects: got %0d coins short expected 0", q_coin.size()); end
        n_checks++;
        if (nickel_cnt !== CNT_W'(m_n)) begin n_fail++; $display("FAIL nickel_cnt: got %0d expected %0d", nickel_cnt, m_n); end
        n_checks++;
        if (dime_cnt !== CNT_W'(m_d)) begin n_fail++; $display("FAIL dime_cnt: got %0d expected %0d", dime_cnt, m_d); end
        q_coin.delete(); q_short.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({req_ready, done, eject_n, eject_d, fault} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, done, eject_n, eject_d, fault});
        end
        n_checks++;
        if ({nickel_cnt, dime_cnt, short_amt} !== '0) begin
            n_fail++; $display("FAIL reset_data: got n=%0d d=%0d s=%0d expected 0", nickel_cnt, dime_cnt, short_amt);
        end
        n_checks++;
        if (exact_only !== 1'b1) begin n_fail++; $display("FAIL reset_exact_only: got %b expected 1", exact_only); end
    endtask

    task automatic test_mixed_change();
        int lat;
        do_reset(); do_refill(0, 5); do_refill(1, 5);
        n_checks++;
        if (exact_only !== model_exact()) begin n_fail++; $display("FAIL exact_only_full: got %b expected %b", exact_only, model_exact()); end
        pay_and_check(3, 0, lat);
    endtask

    task automatic test_nickels_only();
        int lat;
        do_reset(); do_refill(0, 5);
        pay_and_check(2, 0, lat);
    endtask

    task automatic test_shortfall();
        int lat;
        do_reset(); do_refill(0, 1);
        pay_and_check(4, 0, lat);
        n_checks++;
        if (exact_only !== 1'b1) begin n_fail++; $display("FAIL exact_only_empty: got %b expected 1", exact_only); end
    endtask

    task automatic test_jam_fault();
        int fault_at;
        bit seen, saw_done;
        do_reset(); do_refill(0, 5);
        @(negedge clk);
        req_valid = 1'b1; req_amt = AMT_W'(1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); req_valid = 1'b0;
            if (eject_n) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL jam_eject: got no eject expected eject_n"); end
        @(negedge clk);
        fault_at = -1; saw_done = 1'b0;
        for (int k = 1; k <= 40 && fault_at < 0; k++) begin
            @(negedge clk);
            if (fault) fault_at = k;
            if (done) saw_done = 1'b1;
        end
        n_checks++;
        if (fault_at != TIMEOUT) begin n_fail++; $display("FAIL fault_latency: got %0d expected %0d", fault_at, TIMEOUT); end
        n_checks++;
        if (req_ready !== 1'b0 || saw_done) begin
            n_fail++; $display("FAIL fault_state: got ready=%b done_seen=%b expected 0/0", req_ready, saw_done);
        end
        req_valid = 1'b1; req_amt = AMT_W'(2);
        do_refill(1, 3);
        req_valid = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || eject_n || eject_d) begin
            n_fail++; $display("FAIL fault_sticky: got fault=%b ej=%b%b expected 1 00", fault, eject_d, eject_n);
        end
        n_checks++;
        if (dime_cnt !== CNT_W'(m_d) || nickel_cnt !== CNT_W'(m_n)) begin
            n_fail++; $display("FAIL fault_refill: got n=%0d d=%0d expected n=%0d d=%0d", nickel_cnt, dime_cnt, m_n, m_d);
        end
        @(negedge clk); fault_clr = 1'b1;
        @(negedge clk); fault_clr = 1'b0;
        n_checks++;
        if (fault !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL fault_clear: got fault=%b ready=%b expected 0/1", fault, req_ready);
        end
    endtask

    task automatic test_saturation();
        int lat;
        do_reset(); do_refill(0, 63);
        pay_and_check(1, 10, lat);
        n_checks++;
        if (lat != 5) begin n_fail++; $display("FAIL one_coin_latency: got %0d expected 5", lat); end
        pay_and_check(0, 0, lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL zero_req_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_reset_abort();
        bit seen, saw_done;
        do_reset(); do_refill(0, 5); do_refill(1, 5);
        @(negedge clk);
        req_valid = 1'b1; req_amt = AMT_W'(3);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); req_valid = 1'b0;
            if (eject_d) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL abort_eject: got no eject expected eject_d"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; m_n = 0; m_d = 0;
        n_checks++;
        if ({req_ready, done, fault, nickel_cnt, dime_cnt} !== {1'b1, 1'b0, 1'b0, {(2*CNT_W){1'b0}}}) begin
            n_fail++; $display("FAIL abort_state: got ready=%b done=%b n=%0d d=%0d expected 1 0 0 0", req_ready, done, nickel_cnt, dime_cnt);
        end
        saw_done = 1'b0;
        repeat (5) begin @(negedge clk); if (done || eject_n || eject_d) saw_done = 1'b1; end
        n_checks++;
        if (saw_done) begin n_fail++; $display("FAIL abort_quiet: got activity expected none after reset"); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_reset(); do_refill(0, 3); do_refill(1, 2);
        pay_and_check(7, 0, lat);
        pay_and_check(1, 0, lat);
        n_checks++;
        if (exact_only !== 1'b1) begin n_fail++; $display("FAIL exact_only_drained: got %b expected 1", exact_only); end
        do_refill(0, 4);
        @(negedge clk); drop_sense = 1'b1;
        repeat (2) @(negedge clk);
        drop_sense = 1'b0;
        n_checks++;
        if (nickel_cnt !== CNT_W'(m_n) || req_ready !== 1'b1 || fault !== 1'b0) begin
            n_fail++; $display("FAIL idle_sense: got n=%0d ready=%b fault=%b expected n=%0d 1 0", nickel_cnt, req_ready, fault, m_n);
        end
        pay_and_check(3, 0, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mixed_change();
        test_nickels_only();
        test_shortfall();
        test_jam_fault();
        test_saturation();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
